// File: rtl/fc_layer_par.sv
// Fully-connected layer y = act(W*x + b) with P parallel MAC lanes.
// Streams x in, then computes and streams out G = M/P groups of P neurons.
module fc_layer_par #(
  parameter int M    = 8,
  parameter int N    = 6,
  parameter int T    = 16,
  parameter int P    = 2,
  parameter int FRAC = 0,
  parameter int RELU = 1,
  localparam int G   = M / P,
  localparam int AW  = (G * N > 1) ? $clog2(G * N) : 1,
  localparam int BW  = (G > 1) ? $clog2(G) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [T-1:0]    s_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [T-1:0]    m_data,
  output logic [AW-1:0]   w_addr,
  input  logic [P*T-1:0]  w_data,
  output logic [BW-1:0]   b_addr,
  input  logic [P*T-1:0]  b_data
);

  localparam int ACCW = 2 * T + $clog2(N) + 1;
  localparam int SW   = ACCW + 1;
  localparam int CW   = $clog2(N + 2);
  localparam int XW   = (N > 1) ? $clog2(N) : 1;
  localparam int KW   = (P > 1) ? $clog2(P) : 1;

  localparam logic signed [SW-1:0] SAT_MAX = {{(SW - T + 1){1'b0}}, {(T - 1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW - T + 1){1'b1}}, {(T - 1){1'b0}}};

  typedef enum logic [1:0] {LOAD, COMPUTE, FINISH, OUTPUT} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;   // element index in LOAD, pipeline step in COMPUTE
  logic [BW-1:0]   g_q, g_d;
  logic [KW-1:0]   k_q, k_d;
  logic            s_ready_q, m_valid_q;
  logic            s_fire, m_fire;

  assign s_fire = s_valid && s_ready_q;
  assign m_fire = m_valid_q && m_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    g_d     = g_q;
    k_d     = k_q;
    case (state_q)
      LOAD: begin
        if (s_fire) begin
          if (cnt_q == CW'(N - 1)) begin
            state_d = COMPUTE;
            cnt_d   = '0;
            g_d     = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      COMPUTE: begin
        // N address cycles plus two cycles to drain the product/accumulate stages
        if (cnt_q == CW'(N + 1)) begin
          state_d = FINISH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FINISH: begin
        state_d = OUTPUT;
        k_d     = '0;
      end
      OUTPUT: begin
        if (m_fire) begin
          if (k_q == KW'(P - 1)) begin
            k_d = '0;
            if (g_q == BW'(G - 1)) begin
              state_d = LOAD;
              g_d     = '0;
            end else begin
              state_d = COMPUTE;
              g_d     = g_q + BW'(1);
            end
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= LOAD;
      cnt_q     <= '0;
      g_q       <= '0;
      k_q       <= '0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      g_q       <= g_d;
      k_q       <= k_d;
      s_ready_q <= (state_d == LOAD);
      m_valid_q <= (state_d == OUTPUT);
    end
  end

  logic [T-1:0]           x_mem [N];
  logic signed [T-1:0]    x_rd_q;
  logic                   rd_v_q, pr_v_q;
  logic signed [2*T-1:0]  prod_q [P];
  logic signed [ACCW-1:0] acc_q  [P];
  logic signed [T-1:0]    out_q  [P];
  logic signed [SW-1:0]   sh_w   [P];
  logic signed [T-1:0]    res_w  [P];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_v_q <= 1'b0;
      pr_v_q <= 1'b0;
    end else begin
      rd_v_q <= (state_q == COMPUTE) && (cnt_q < CW'(N));
      pr_v_q <= rd_v_q;
    end
  end

  // NOTE: storage and pipeline data carry no reset; the valid bits above qualify them.
  always_ff @(posedge clk) begin
    if (s_fire) x_mem[cnt_q[XW-1:0]] <= s_data;
    x_rd_q <= x_mem[cnt_q[XW-1:0]];
    for (int p = 0; p < P; p++) begin
      prod_q[p] <= (2*T)'(x_rd_q) * (2*T)'($signed(w_data[p*T +: T]));
      if (state_q == COMPUTE && cnt_q == '0) acc_q[p] <= '0;
      else if (pr_v_q)                       acc_q[p] <= acc_q[p] + ACCW'(prod_q[p]);
    end
  end

  always_comb begin
    for (int p = 0; p < P; p++) begin
      sh_w[p] = (SW'(acc_q[p]) + SW'($signed(b_data[p*T +: T]))) >>> FRAC;
      if (sh_w[p] > SAT_MAX)      res_w[p] = SAT_MAX[T-1:0];
      else if (sh_w[p] < SAT_MIN) res_w[p] = SAT_MIN[T-1:0];
      else                        res_w[p] = sh_w[p][T-1:0];
      if (RELU != 0 && res_w[p][T-1]) res_w[p] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < P; p++) out_q[p] <= '0;
    end else if (state_q == FINISH) begin
      for (int p = 0; p < P; p++) out_q[p] <= res_w[p];
    end
  end

  always_comb begin
    w_addr = AW'(int'(g_q) * N + ((state_q == COMPUTE && cnt_q < CW'(N)) ? int'(cnt_q) : 0));
  end

  assign b_addr  = g_q;
  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data  = out_q[k_q];

endmodule

// File: tb/tb_fc_layer_par.sv
// Directed bench for fc_layer_par: a 4x3 layer for function/handshake/reset,
// plus two 2x3 layers for saturation and fractional shift.
module tb_fc_layer_par;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int last_acc = 0;
  int last_vld = 0;

  // layer A: M=4 N=3 P=2 FRAC=0 RELU=1
  logic        s_valid_a, s_ready_a, m_valid_a, m_ready_a;
  logic [15:0] s_data_a, m_data_a;
  logic [2:0]  w_addr_a;
  logic [0:0]  b_addr_a;
  logic [31:0] w_data_a, b_data_a;
  logic [31:0] w_rom_a [8];
  logic [31:0] b_rom_a [2];

  fc_layer_par #(.M(4), .N(3), .T(16), .P(2), .FRAC(0), .RELU(1)) dut_a (
    .clk(clk), .reset(reset),
    .s_valid(s_valid_a), .s_ready(s_ready_a), .s_data(s_data_a),
    .m_valid(m_valid_a), .m_ready(m_ready_a), .m_data(m_data_a),
    .w_addr(w_addr_a), .w_data(w_data_a), .b_addr(b_addr_a), .b_data(b_data_a)
  );

  always @(posedge clk) begin
    w_data_a <= w_rom_a[w_addr_a];
    b_data_a <= b_rom_a[b_addr_a];
  end

  // layers B (saturation, RELU=0) and C (FRAC=4) share handshake inputs
  logic        s_valid_2, m_ready_2;
  logic        s_ready_b, m_valid_b, s_ready_c, m_valid_c;
  logic [15:0] s_data_b, m_data_b, s_data_c, m_data_c;
  logic [1:0]  w_addr_b, w_addr_c;
  logic [0:0]  b_addr_b, b_addr_c;
  logic [31:0] w_data_b, b_data_b, w_data_c, b_data_c;
  logic [31:0] w_rom_b [4];
  logic [31:0] b_rom_b [2];
  logic [31:0] w_rom_c [4];
  logic [31:0] b_rom_c [2];

  fc_layer_par #(.M(2), .N(3), .T(16), .P(2), .FRAC(0), .RELU(0)) dut_b (
    .clk(clk), .reset(reset),
    .s_valid(s_valid_2), .s_ready(s_ready_b), .s_data(s_data_b),
    .m_valid(m_valid_b), .m_ready(m_ready_2), .m_data(m_data_b),
    .w_addr(w_addr_b), .w_data(w_data_b), .b_addr(b_addr_b), .b_data(b_data_b)
  );

  fc_layer_par #(.M(2), .N(3), .T(16), .P(2), .FRAC(4), .RELU(1)) dut_c (
    .clk(clk), .reset(reset),
    .s_valid(s_valid_2), .s_ready(s_ready_c), .s_data(s_data_c),
    .m_valid(m_valid_c), .m_ready(m_ready_2), .m_data(m_data_c),
    .w_addr(w_addr_c), .w_data(w_data_c), .b_addr(b_addr_c), .b_data(b_data_c)
  );

  always @(posedge clk) begin
    w_data_b <= w_rom_b[w_addr_b];
    b_data_b <= b_rom_b[b_addr_b];
    w_data_c <= w_rom_c[w_addr_c];
    b_data_c <= b_rom_c[b_addr_c];
  end

  typedef struct packed {
    logic [2:0][15:0] x;
    logic [3:0][15:0] y;
    logic             gap;
  } vec_t;

  vec_t tbl [4];

  function automatic logic [31:0] pk(input int l0, input int l1);
    logic [15:0] a;
    logic [15:0] b;
    a = 16'(l0);
    b = 16'(l1);
    return {b, a};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input int x0, input int x1, input int x2,
                         input int y0, input int y1, input int y2, input int y3,
                         input logic gap);
    tbl[i].x[0] = 16'(x0); tbl[i].x[1] = 16'(x1); tbl[i].x[2] = 16'(x2);
    tbl[i].y[0] = 16'(y0); tbl[i].y[1] = 16'(y1);
    tbl[i].y[2] = 16'(y2); tbl[i].y[3] = 16'(y3);
    tbl[i].gap  = gap;
  endtask

  task automatic push_a(input int v);
    int t = 0;
    s_valid_a = 1'b1;
    s_data_a  = 16'(v);
    while (!s_ready_a && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) check("push_a_ready_timeout", int'(s_ready_a), 1);
    @(negedge clk);
    s_valid_a = 1'b0;
    last_acc  = cyc;
  endtask

  task automatic pop_a(input int exp, input string name);
    int t = 0;
    while (!m_valid_a && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin
      check({name, "_valid_timeout"}, int'(m_valid_a), 1);
    end else begin
      last_vld = cyc;
      check(name, $signed(m_data_a), exp);
      m_ready_a = 1'b1;
      @(negedge clk);
      m_ready_a = 1'b0;
    end
  endtask

  task automatic push_2(input int vb, input int vc);
    int t = 0;
    s_valid_2 = 1'b1;
    s_data_b  = 16'(vb);
    s_data_c  = 16'(vc);
    while (!s_ready_b && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) check("push_2_ready_timeout", int'(s_ready_b), 1);
    @(negedge clk);
    s_valid_2 = 1'b0;
  endtask

  task automatic pop_2(input int eb, input int ec, input string name);
    int t = 0;
    while (!m_valid_b && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin
      check({name, "_valid_timeout"}, int'(m_valid_b), 1);
    end else begin
      check({name, "_sat"}, $signed(m_data_b), eb);
      check({name, "_frac_valid"}, int'(m_valid_c), 1);
      check({name, "_frac"}, $signed(m_data_c), ec);
      m_ready_2 = 1'b1;
      @(negedge clk);
      m_ready_2 = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1);
  end

  initial begin
    int seen;
    // ROM A: word g*3+j = {W[2g+1][j], W[2g][j]}
    w_rom_a[0] = pk(1, 2);   w_rom_a[1] = pk(1, 0);   w_rom_a[2] = pk(1, -1);
    w_rom_a[3] = pk(0, -1);  w_rom_a[4] = pk(0, -1);  w_rom_a[5] = pk(1, -1);
    w_rom_a[6] = '0;         w_rom_a[7] = '0;
    b_rom_a[0] = pk(0, 5);   b_rom_a[1] = pk(-10, 4);
    for (int i = 0; i < 4; i++) w_rom_b[i] = (i < 3) ? pk(32767, 32767) : '0;
    b_rom_b[0] = '0;         b_rom_b[1] = '0;
    w_rom_c[0] = pk(32, 0);  w_rom_c[1] = '0;  w_rom_c[2] = '0;  w_rom_c[3] = '0;
    b_rom_c[0] = pk(16, 100); b_rom_c[1] = '0;

    set_vec(0,  1,  2,  3,   6, 4,  0, 0, 1'b0);
    set_vec(1,  3, -1,  2,   4, 9,  0, 0, 1'b1);
    set_vec(2, -5,  0, 20,  15, 0, 10, 0, 1'b0);
    set_vec(3,  0,  0,  0,   0, 5,  0, 4, 1'b0);

    // reset with s_valid asserted: the element must be ignored
    reset = 1'b1;
    s_valid_a = 1'b1; s_data_a = 16'd99; m_ready_a = 1'b0;
    s_valid_2 = 1'b1; s_data_b = 16'd99; s_data_c = 16'd99; m_ready_2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", int'(s_ready_a), 0);
    check("rst_m_valid", int'(m_valid_a), 0);
    check("rst_m_data",  int'(m_data_a), 0);
    check("rst_w_addr",  int'(w_addr_a), 0);
    check("rst_b_addr",  int'(b_addr_a), 0);
    reset = 1'b0; s_valid_a = 1'b0; s_valid_2 = 1'b0;
    @(negedge clk);
    check("s_ready_after_reset", int'(s_ready_a), 1);

    for (int i = 0; i < 4; i++) begin
      if (tbl[i].gap) m_ready_a = 1'b1;
      for (int j = 0; j < 3; j++) begin
        push_a($signed(tbl[i].x[j]));
        if (tbl[i].gap && j < 2) @(negedge clk);
      end
      check($sformatf("vec%0d_s_ready_busy", i), int'(s_ready_a), 0);
      for (int k = 0; k < 4; k++) begin
        pop_a($signed(tbl[i].y[k]), $sformatf("vec%0d_y%0d", i, k));
        if (i == 0 && k == 0) check("first_valid_latency", last_vld - last_acc, 6);
      end
      m_ready_a = 1'b0;
    end

    // backpressure on the first output of group 0
    push_a(1); push_a(2); push_a(3);
    seen = 0;
    while (!m_valid_a && seen < 100) begin @(negedge clk); seen++; end
    for (int c = 0; c < 10; c++) begin
      check($sformatf("bp%0d_m_valid", c), int'(m_valid_a), 1);
      check($sformatf("bp%0d_m_data", c), $signed(m_data_a), 6);
      check($sformatf("bp%0d_w_addr_group0", c), int'(w_addr_a < 3'd3), 1);
      @(negedge clk);
    end
    pop_a(6, "bp_y0"); pop_a(4, "bp_y1"); pop_a(0, "bp_y2"); pop_a(0, "bp_y3");

    // reset after 2 of 3 inputs: partial vector must be discarded
    push_a(7); push_a(7);
    reset = 1'b1;
    @(negedge clk);
    check("midload_rst_s_ready", int'(s_ready_a), 0);
    check("midload_rst_m_valid", int'(m_valid_a), 0);
    reset = 1'b0;
    push_a(1); push_a(2); push_a(3);
    pop_a(6, "midload_y0"); pop_a(4, "midload_y1");
    pop_a(0, "midload_y2"); pop_a(0, "midload_y3");

    // reset during OUTPUT at k=1: nothing more may come out
    push_a(1); push_a(2); push_a(3);
    pop_a(6, "midout_y0");
    check("midout_k1_m_valid", int'(m_valid_a), 1);
    check("midout_k1_m_data", $signed(m_data_a), 4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      if (m_valid_a) seen++;
      @(negedge clk);
    end
    check("midout_no_valid_after_reset", seen, 0);
    check("midout_s_ready", int'(s_ready_a), 1);
    push_a(0); push_a(0); push_a(0);
    pop_a(0, "midout_new_y0"); pop_a(5, "midout_new_y1");
    pop_a(0, "midout_new_y2"); pop_a(4, "midout_new_y3");

    // saturation (B) and fractional shift (C)
    push_2(32767, 16); push_2(32767, 0); push_2(32767, 0);
    pop_2(32767, 33, "pos_y0"); pop_2(32767, 6, "pos_y1");
    push_2(-32768, -16); push_2(-32768, 0); push_2(-32768, 0);
    pop_2(-32768, 0, "neg_y0"); pop_2(-32768, 6, "neg_y1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
